half_adder_add_ctrl: RTL and testbench

Sequential controller that performs a full WIDTH-bit addition with carry-out using only a parallel array of half adders. It works by iterative carry re-injection: each cycle it computes sum = A^B and carry = A&B, then feeds the carry back shifted left until no carry remains. It sits between a requesting block (start/done handshake) and the half-adder datapath, and is the team's reference sequencer for that datapath.

---
 rtl/half_adder_pkg.sv | 17 +
 rtl/half_adder_array.sv | 18 +
 rtl/half_adder_add_ctrl.sv | 92 +++++++++
 tb/tb_half_adder_add_ctrl.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/half_adder_pkg.sv
// Shared types and sizing helpers for the half-adder based addition sequencer.
package half_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 4;

  // Bits needed to hold an iteration count in 0..width.
  function automatic int iter_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/half_adder_array.sv
// WIDTH independent half adders; purely combinational.
module half_adder_array
  import half_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] carry
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    assign sum[i]   = a[i] ^ b[i];
    assign carry[i] = a[i] & b[i];
  end

endmodule

// File: rtl/half_adder_add_ctrl.sv
// Full WIDTH-bit adder built from a half-adder array by re-injecting the
// shifted carry each cycle until no carry remains. start/done handshake.
module half_adder_add_ctrl
  import half_adder_pkg::*;
#(
  parameter int  WIDTH = DEFAULT_WIDTH,
  localparam int CW    = iter_cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [CW-1:0]    iter_count
);

  state_t           state, nxt;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] ha_sum, ha_carry;
  logic [WIDTH-1:0] op_b_nxt;
  logic             flag;
  logic [CW-1:0]    cnt;

  half_adder_array #(.WIDTH(WIDTH)) u_ha (
    .a     (op_a),
    .b     (op_b),
    .sum   (ha_sum),
    .carry (ha_carry)
  );

  // Carries move up one bit; the top carry leaves the word and lands in flag.
  assign op_b_nxt = {ha_carry[WIDTH-2:0], 1'b0};

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // Next-state: b==0 needs no iterations; RUN ends once the re-injected carry is zero.
  always_comb begin
    nxt = state;
    case (state)
      IDLE: if (start) nxt = (b == '0) ? DONE : RUN;
      RUN:  if (op_b_nxt == '0) nxt = DONE;
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Operand, carry flag and iteration counter; results stay put outside RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a <= '0;
      op_b <= '0;
      flag <= 1'b0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_a <= a;
          op_b <= b;
          flag <= 1'b0;
          cnt  <= '0;
        end
        RUN: begin
          op_a <= ha_sum;
          op_b <= op_b_nxt;
          flag <= flag | ha_carry[WIDTH-1];
          cnt  <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  // Each pass pushes the lowest pending carry up a bit, so k can never exceed WIDTH.
  always_ff @(posedge clk) begin
    if (!rst) assert (int'(cnt) <= WIDTH);
  end

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign sum        = op_a;
  assign cout       = flag;
  assign iter_count = cnt;

endmodule

// File: tb/tb_half_adder_add_ctrl.sv
// Directed + swept bench with an expected-result queue for half_adder_add_ctrl.
module tb_half_adder_add_ctrl;
  import half_adder_pkg::*;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  typedef struct {
    logic [W-1:0]  s;
    logic          c;
    logic [CW-1:0] k;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [W-1:0]  a, b;
  logic          busy, done, cout;
  logic [W-1:0]  sum;
  logic [CW-1:0] iter_count;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  half_adder_add_ctrl #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .sum        (sum),
    .cout       (cout),
    .iter_count (iter_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
  endtask

  // Reference: sum/cout straight from a+b; k from the carry re-injection definition.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t         e;
    logic [W:0]   t;
    logic [W-1:0] p, q, c;
    t   = {1'b0, x} + {1'b0, y};
    e.s = t[W-1:0];
    e.c = t[W];
    e.k = '0;
    p = x;
    q = y;
    while (q != '0) begin
      c   = p & q;
      p   = p ^ q;
      q   = c << 1;
      e.k = e.k + 1'b1;
    end
    return e;
  endfunction

  // Wait (bounded) for done, starting at cycle index 'first' after the accept edge.
  task automatic finish_op(input string tag, input int first);
    exp_t e;
    int   lat;
    bit   got;
    lat = 0;
    got = 0;
    for (int i = first; i <= W + 2 && !got; i++) begin
      @(negedge clk);
      if (i == 1) chk({tag, " busy_after_accept"}, busy, 1);
      if (done) begin
        got = 1;
        lat = i;
      end
    end
    chk({tag, " done_seen"}, got, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, " latency"}, lat, int'(e.k) + 1);
      chk({tag, " sum"}, sum, e.s);
      chk({tag, " cout"}, cout, e.c);
      chk({tag, " iter_count"}, iter_count, e.k);
      chk({tag, " iter_le_w"}, (int'(iter_count) <= W), 1);
    end
    @(negedge clk);
    chk({tag, " done_one_cycle"}, done, 0);
    chk({tag, " idle_after_done"}, busy, 0);
  endtask

  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input bit hold, input string tag);
    @(negedge clk);
    a = x;
    b = y;
    start = 1'b1;
    sb.push_back(model(x, y));
    @(posedge clk);
    #1;
    if (!hold) begin
      start = 1'b0;
      a = W'($urandom);
      b = W'($urandom);
    end
    finish_op(tag, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] idx;
    int         r;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #1;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset sum", sum, 0);
    chk("reset cout", cout, 0);
    chk("reset iter", iter_count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    do_op(4'd3, 4'd0, 0, "b_zero");
    do_op(4'd0, 4'd3, 0, "k1");
    do_op(4'd1, 4'd15, 0, "worst");

    // start held through RUN and DONE: one result, then an IDLE gap before re-accept
    do_op(4'd9, 4'd7, 1, "hold");
    sb.push_back(model(4'd9, 4'd7));
    @(negedge clk);
    chk("hold reaccept busy", busy, 1);
    start = 1'b0;
    finish_op("hold_second", 2);

    // reset in the middle of RUN
    @(negedge clk);
    a = 4'd1; b = 4'd15; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("midrun iter before rst", iter_count, 2);
    #1 rst = 1'b1;
    #1;
    chk("midrun rst busy", busy, 0);
    chk("midrun rst done", done, 0);
    chk("midrun rst sum", sum, 0);
    chk("midrun rst cout", cout, 0);
    chk("midrun rst iter", iter_count, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no done during rst", done, 0);
    end
    rst = 1'b0;
    do_op(4'd5, 4'd6, 0, "after_rst");

    // every operand pair, visited in a scrambled order
    r = $urandom_range(255);
    for (int i = 0; i < 256; i++) begin
      idx = 8'((i * 37 + r) % 256);
      do_op(idx[7:4], idx[3:0], 0, "sweep");
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
